// File: rtl/coherent_bus_arbiter_pkg.sv
// Shared types and constants for the coherent bus arbiter: FSM encoding,
// L2 request view and block data width helpers.
package coherent_bus_arbiter_pkg;

  localparam int unsigned WordWidth  = 32;
  localparam int unsigned DATA_WIDTH = WordWidth * 2;

  typedef enum logic [2:0] {
    StIdle,
    StSnoop,
    StCollect,
    StTransfer,
    StReadL2,
    StResp
  } arb_state_t;

  typedef struct packed {
    logic        ren;
    logic [31:0] addr;
  } l2_state_t;

  function automatic int unsigned data_width(int unsigned block_size);
    return WordWidth * block_size;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority picker: one-hot grant of the first request at or
// after the pointer, wrapping from CPUS-1 back to 0.
module rr_picker #(
  parameter int unsigned CPUS = 4,
  localparam int unsigned PtrW = $clog2(CPUS)
) (
  input  logic [CPUS-1:0] req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [CPUS-1:0] gnt_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    logic [PtrW-1:0] sel;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned k = 0; k < CPUS; k++) begin
      idx = 32'(ptr_i) + k;
      if (idx >= CPUS) idx = idx - CPUS;
      sel = PtrW'(idx);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coherent_bus_arbiter.sv
// Snooping bus arbiter: grants one L1 port at a time, snoops the others and
// returns the block from the lowest-index hitter or from L2 on a miss.
module coherent_bus_arbiter
  import coherent_bus_arbiter_pkg::*;
#(
  parameter int unsigned CPUS          = 4,
  parameter int unsigned BLOCK_SIZE    = DATA_WIDTH / WordWidth,
  parameter int unsigned SNOOP_TIMEOUT = 16,
  localparam int unsigned DW           = data_width(BLOCK_SIZE),
  localparam int unsigned PtrW         = $clog2(CPUS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [CPUS-1:0]    req_rd_i,
  input  logic [CPUS-1:0]    req_rdx_i,
  input  logic [CPUS*32-1:0] req_addr_i,
  input  logic [CPUS-1:0]    snoop_hit_i,
  input  logic [CPUS-1:0]    snoop_done_i,
  input  logic [CPUS*DW-1:0] snoop_data_i,
  input  logic               l2_ack_i,
  input  logic [DW-1:0]      l2_rdata_i,
  output logic [CPUS-1:0]    grant_o,
  output logic [CPUS-1:0]    snoop_req_o,
  output logic [31:0]        snoop_addr_o,
  output logic               snoop_inv_o,
  output logic               l2_ren_o,
  output logic [31:0]        l2_addr_o,
  output logic [CPUS-1:0]    resp_valid_o,
  output logic [DW-1:0]      resp_data_o,
  output logic               resp_shared_o,
  output logic               timeout_err_o
);

  arb_state_t      state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [CPUS-1:0] grant_q, grant_d;
  logic [31:0]     addr_q, addr_d;
  logic            rdx_q, rdx_d;
  logic [CPUS-1:0] done_q, done_d;
  logic [CPUS-1:0] hit_q, hit_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            tout_q, tout_d;

  logic [CPUS-1:0] req_any, pick_gnt;
  logic [PtrW-1:0] pick_idx, hit_idx;
  logic            pick_rdx;
  logic [31:0]     pick_addr;
  logic [CPUS-1:0] done_acc, hit_acc;
  logic            all_done, cnt_expired;
  l2_state_t       l2;

  assign req_any = req_rd_i | req_rdx_i;

  rr_picker #(
    .CPUS (CPUS)
  ) u_picker (
    .req_i (req_any),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < CPUS; i++) begin
      if (pick_gnt[i]) pick_idx = PtrW'(i);
    end
    hit_idx = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (hit_q[i]) hit_idx = PtrW'(i);
    end
  end

  // rdx wins when a port raises both request lines
  assign pick_rdx  = |(pick_gnt & req_rdx_i);
  assign pick_addr = req_addr_i[32*pick_idx +: 32];

  // Only non-owners are snooped; a hit counts once its responder is done
  assign done_acc    = done_q | (snoop_done_i & ~grant_q);
  assign hit_acc     = hit_q | (snoop_hit_i & snoop_done_i & ~grant_q);
  assign all_done    = &(done_acc | grant_q);
  assign cnt_expired = (cnt_q == 8'(SNOOP_TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (|req_any) state_d = StSnoop;
      StSnoop:    state_d = StCollect;
      StCollect:  if (all_done || cnt_expired) state_d = (|hit_acc) ? StTransfer : StReadL2;
      StTransfer: state_d = StResp;
      StReadL2:   if (l2_ack_i) state_d = StResp;
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    rdx_d   = rdx_q;
    done_d  = done_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tout_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req_any) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          addr_d  = pick_addr;
          rdx_d   = pick_rdx;
        end
      end
      StSnoop: begin
        done_d = '0;
        hit_d  = '0;
        cnt_d  = '0;
      end
      StCollect: begin
        done_d = done_acc;
        hit_d  = hit_acc;
        cnt_d  = cnt_q + 8'd1;
        tout_d = cnt_expired && !all_done;
      end
      StTransfer: data_d = snoop_data_i[DW*hit_idx +: DW];
      StReadL2:   if (l2_ack_i) data_d = l2_rdata_i;
      StResp: begin
        grant_d = '0;
        ptr_d   = (32'(owner_q) == CPUS - 1) ? '0 : owner_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      rdx_q   <= 1'b0;
      done_q  <= '0;
      hit_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      rdx_q   <= rdx_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    l2.ren        = (state_q == StReadL2);
    l2.addr       = addr_q;
    grant_o       = grant_q;
    snoop_req_o   = '0;
    snoop_addr_o  = addr_q;
    snoop_inv_o   = rdx_q && (state_q != StIdle);
    l2_ren_o      = l2.ren;
    l2_addr_o     = l2.addr;
    resp_valid_o  = '0;
    resp_data_o   = data_q;
    resp_shared_o = 1'b0;
    timeout_err_o = tout_q;
    case (state_q)
      StSnoop: snoop_req_o = ~grant_q;
      StResp: begin
        resp_valid_o  = grant_q;
        resp_shared_o = (|hit_q) && !rdx_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherent_bus_arbiter.sv
// Scoreboard bench for coherent_bus_arbiter: directed transactions push
// expected snoops, L2 reads, timeouts and responses; monitors pop and compare.
module tb_coherent_bus_arbiter;

  localparam int unsigned CPUS = 4;
  localparam int unsigned DW   = 64;

  localparam logic [63:0] D0  = 64'h0D0D_0000_1111_0D0D;
  localparam logic [63:0] D2  = 64'h0D2D_2222_3333_0D2D;
  localparam logic [63:0] D3  = 64'h0D3D_4444_5555_0D3D;
  localparam logic [63:0] DA5 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] L2A = 64'h1122_3344_5566_7788;
  localparam logic [63:0] L2B = 64'h99AA_BBCC_DDEE_FF00;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [CPUS-1:0]    req_rd = '0, req_rdx = '0;
  logic [CPUS*32-1:0] req_addr = '0;
  logic [CPUS-1:0]    snoop_hit = '0, snoop_done = '0;
  logic [CPUS*DW-1:0] snoop_data = '0;
  logic               l2_ack = 1'b0;
  logic [DW-1:0]      l2_rdata = '0;
  logic [CPUS-1:0]    grant, snoop_req, resp_valid;
  logic [31:0]        snoop_addr, l2_addr;
  logic               snoop_inv, l2_ren, resp_shared, timeout_err;
  logic [DW-1:0]      resp_data;

  coherent_bus_arbiter #(
    .CPUS          (CPUS),
    .BLOCK_SIZE    (2),
    .SNOOP_TIMEOUT (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_rd_i      (req_rd),
    .req_rdx_i     (req_rdx),
    .req_addr_i    (req_addr),
    .snoop_hit_i   (snoop_hit),
    .snoop_done_i  (snoop_done),
    .snoop_data_i  (snoop_data),
    .l2_ack_i      (l2_ack),
    .l2_rdata_i    (l2_rdata),
    .grant_o       (grant),
    .snoop_req_o   (snoop_req),
    .snoop_addr_o  (snoop_addr),
    .snoop_inv_o   (snoop_inv),
    .l2_ren_o      (l2_ren),
    .l2_addr_o     (l2_addr),
    .resp_valid_o  (resp_valid),
    .resp_data_o   (resp_data),
    .resp_shared_o (resp_shared),
    .timeout_err_o (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] data;
    logic        shared;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [3:0]  req;
    logic        inv;
    logic [31:0] addr;
  } snoop_t;

  resp_t       rq[$];
  snoop_t      sq[$];
  logic [31:0] lq[$];
  int          tq[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int l2_lat = 0;
  int l2_cnt = 0;
  logic l2_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expire(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // L2 model: ack l2_lat cycles after the first l2_ren cycle
  always @(negedge clk) begin
    if (rst) begin
      l2_ack = 1'b0;
      l2_cnt = 0;
    end else if (l2_ack) begin
      l2_ack = 1'b0;
      l2_cnt = 0;
    end else if (l2_ren) begin
      if (l2_cnt == l2_lat) l2_ack = 1'b1;
      else l2_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      l2_seen = 1'b0;
    end else begin
      if (resp_valid !== '0) begin
        if (rq.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid), 64'd0);
        end else begin
          resp_t e;
          e = rq.pop_front();
          chk("resp_valid", 64'(resp_valid), 64'(e.valid));
          chk("resp_data", resp_data, e.data);
          chk("resp_shared", 64'(resp_shared), 64'(e.shared));
          chk("resp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (snoop_req !== '0) begin
        if (sq.size() == 0) begin
          chk("snoop_unexpected", 64'(snoop_req), 64'd0);
        end else begin
          snoop_t s;
          s = sq.pop_front();
          chk("snoop_req", 64'(snoop_req), 64'(s.req));
          chk("snoop_inv", 64'(snoop_inv), 64'(s.inv));
          chk("snoop_addr", 64'(snoop_addr), 64'(s.addr));
        end
      end
      if (l2_ren && !l2_seen) begin
        l2_seen = 1'b1;
        if (lq.size() == 0) chk("l2_unexpected", 64'(l2_ren), 64'd0);
        else chk("l2_addr", 64'(l2_addr), 64'(lq.pop_front()));
      end
      if (!l2_ren) l2_seen = 1'b0;
      if (timeout_err) begin
        if (tq.size() == 0) chk("timeout_unexpected", 64'(timeout_err), 64'd0);
        else chk("timeout_cycle", 64'(cyc), 64'(tq.pop_front()));
      end
    end
  end

  task automatic set_resp(input logic [3:0] done, input logic [3:0] hit,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] d3);
    snoop_done = done;
    snoop_hit  = hit;
    snoop_data = {d3, d2, d1, d0};
  endtask

  task automatic issue(input int p, input logic rdx, input logic [31:0] addr);
    req_addr[32*p +: 32] = addr;
    if (rdx) req_rdx[p] = 1'b1;
    else req_rd[p] = 1'b1;
  endtask

  task automatic push_resp(input logic [3:0] v, input logic [63:0] d, input logic sh, input int c);
    resp_t e;
    e.valid = v; e.data = d; e.shared = sh; e.cyc = c;
    rq.push_back(e);
  endtask

  task automatic push_snoop(input logic [3:0] r, input logic inv, input logic [31:0] a);
    snoop_t s;
    s.req = r; s.inv = inv; s.addr = a;
    sq.push_back(s);
  endtask

  task automatic wait_grant(input int p);
    logic [3:0] want;
    want = 4'(1 << p);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (grant == want) begin
        req_rd[p]  = 1'b0;
        req_rdx[p] = 1'b0;
        return;
      end
    end
    expire("grant_wait");
    req_rd[p]  = 1'b0;
    req_rdx[p] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rq.size() == 0) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    expire("resp_drain");
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_snoop_req"}, 64'(snoop_req), 64'd0);
    chk({tag, "_snoop_inv"}, 64'(snoop_inv), 64'd0);
    chk({tag, "_snoop_addr"}, 64'(snoop_addr), 64'd0);
    chk({tag, "_l2_ren"}, 64'(l2_ren), 64'd0);
    chk({tag, "_l2_addr"}, 64'(l2_addr), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_data"}, resp_data, 64'd0);
    chk({tag, "_resp_shared"}, 64'(resp_shared), 64'd0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Two readers with pointer at 0: port 1 first, then port 3; port 0 hits
    set_resp(4'b1111, 4'b0001, D0, 64'd0, 64'd0, 64'd0);
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h0000_1000);
    issue(3, 1'b0, 32'h0000_3000);
    c = cyc;
    push_snoop(4'b1101, 1'b0, 32'h0000_1000);
    push_resp(4'b0010, D0, 1'b1, c + 4);
    push_snoop(4'b0111, 1'b0, 32'h0000_3000);
    push_resp(4'b1000, D0, 1'b1, c + 9);
    wait_grant(1);
    wait_grant(3);
    wait_drain();

    // Port 0 rdx, port 2 hits: invalidating snoop, not shared
    set_resp(4'b1111, 4'b0100, 64'd0, 64'd0, DA5, 64'd0);
    @(posedge clk); #1;
    issue(0, 1'b1, 32'h0000_0100);
    c = cyc;
    push_snoop(4'b1110, 1'b1, 32'h0000_0100);
    push_resp(4'b0001, DA5, 1'b0, c + 4);
    wait_grant(0);
    wait_drain();

    // Port 1 rd, all miss, L2 acks 3 cycles after l2_ren
    set_resp(4'b1111, 4'b0000, D0, 64'd0, D2, D3);
    l2_lat   = 3;
    l2_rdata = L2A;
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h0000_2240);
    c = cyc;
    push_snoop(4'b1101, 1'b0, 32'h0000_2240);
    lq.push_back(32'h0000_2240);
    push_resp(4'b0010, L2A, 1'b0, c + 7);
    wait_grant(1);
    wait_drain();

    // Port 2 rd, port 3 never done: 16 collect cycles, timeout, then L2
    set_resp(4'b0111, 4'b1000, 64'd0, 64'd0, 64'd0, D3);
    l2_lat   = 1;
    l2_rdata = L2B;
    @(posedge clk); #1;
    issue(2, 1'b0, 32'h0000_3000);
    c = cyc;
    push_snoop(4'b1011, 1'b0, 32'h0000_3000);
    tq.push_back(c + 18);
    lq.push_back(32'h0000_3000);
    push_resp(4'b0100, L2B, 1'b0, c + 20);
    wait_grant(2);
    wait_drain();

    // Pointer at 3 wraps to port 0; ports 2 and 3 hit, lowest index wins
    set_resp(4'b1111, 4'b1100, 64'd0, 64'd0, D2, D3);
    @(posedge clk); #1;
    issue(0, 1'b0, 32'h0000_0040);
    c = cyc;
    push_snoop(4'b1110, 1'b0, 32'h0000_0040);
    push_resp(4'b0001, D2, 1'b1, c + 4);
    wait_grant(0);
    wait_drain();

    // Reset while waiting on a slow L2 read
    set_resp(4'b1111, 4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
    l2_lat = 20;
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h0000_0500);
    push_snoop(4'b1101, 1'b0, 32'h0000_0500);
    lq.push_back(32'h0000_0500);
    wait_grant(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (l2_ren) break;
    end
    chk("l2_ren_before_reset", 64'(l2_ren), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    l2_lat = 0;

    // Pointer must restart at 0: port 0 ahead of port 1
    set_resp(4'b1111, 4'b1000, 64'd0, 64'd0, 64'd0, D3);
    @(posedge clk); #1;
    issue(0, 1'b0, 32'h0000_0600);
    issue(1, 1'b0, 32'h0000_0700);
    c = cyc;
    push_snoop(4'b1110, 1'b0, 32'h0000_0600);
    push_resp(4'b0001, D3, 1'b1, c + 4);
    push_snoop(4'b1101, 1'b0, 32'h0000_0700);
    push_resp(4'b0010, D3, 1'b1, c + 9);
    wait_grant(0);
    wait_grant(1);
    wait_drain();

    chk("resp_queue_empty", 64'(rq.size()), 64'd0);
    chk("snoop_queue_empty", 64'(sq.size()), 64'd0);
    chk("l2_queue_empty", 64'(lq.size()), 64'd0);
    chk("timeout_queue_empty", 64'(tq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coherent_bus_arbiter.md
COHERENT_BUS_ARBITER -- requirements
Module: coherent_bus_arbiter

Interface
REQ-001 SHALL have parameter CPUS, default 4: number of requesting L1 ports, 2..16.
REQ-002 SHALL have parameter BLOCK_SIZE, default 2: words per transfer; DATA_WIDTH = 32*BLOCK_SIZE.
REQ-003 SHALL have parameter SNOOP_TIMEOUT, default 16: maximum number of collect cycles, 2..255.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: CLK input 1, the clock, rising edge.
REQ-005 RST input 1: asynchronous active-high reset.
REQ-006 req_rd input CPUS: per-port read-shared request.
REQ-007 req_rdx input CPUS: per-port read-exclusive request.
REQ-008 req_addr input CPUS x 32: per-port block address.
REQ-009 snoop_hit input CPUS: responder holds the block valid.
REQ-010 snoop_done input CPUS: responder finished its lookup.
REQ-011 snoop_data input CPUS x DATA_WIDTH: responder block data.
REQ-012 l2_ack input 1: L2 read complete.
REQ-013 l2_rdata input DATA_WIDTH: L2 read data.
REQ-014 grant output CPUS: one-hot owner of the current transaction.
REQ-015 snoop_req output CPUS: snoop strobe to every non-owner.
REQ-016 snoop_addr output 32: latched owner address.
REQ-017 snoop_inv output 1: the snoop is an invalidation (rdx).
REQ-018 l2_ren output 1: L2 read request.
REQ-019 l2_addr output 32: L2 address.
REQ-020 resp_valid output CPUS: one-cycle response to the owner.
REQ-021 resp_data output DATA_WIDTH: response block.
REQ-022 resp_shared output 1: another cache keeps a copy.
REQ-023 timeout_err output 1: one-cycle pulse on snoop timeout.

Function
REQ-024 SHALL implement states IDLE, SNOOP, COLLECT, TRANSFER, READ_L2, RESP.
REQ-025 In IDLE, a port is requesting when req_rd|req_rdx is set; SHALL grant the first requesting port at or after the round-robin pointer, wrapping from CPUS-1 to 0, latching its address and the rdx bit, and go to SNOOP on the next edge.
REQ-026 If a port asserts both req_rd and req_rdx, SHALL treat the request as rdx.
REQ-027 grant SHALL stay stable from SNOOP through RESP; the owner's requests are ignored until RESP.
REQ-028 SNOOP SHALL last one cycle, with snoop_req = ~grant, then go to COLLECT.
REQ-029 COLLECT SHALL accumulate sticky done and hit vectors over non-owners.
REQ-030 COLLECT SHALL exit the cycle all non-owner dones are set, or after SNOOP_TIMEOUT cycles; on timeout, missing responders count as misses and timeout_err pulses.
REQ-031 After COLLECT, any hit SHALL go to TRANSFER and no hit SHALL go to READ_L2.
REQ-032 TRANSFER SHALL, in one cycle, capture snoop_data of the lowest-index hitter into resp_data, then go to RESP.
REQ-033 READ_L2 SHALL hold l2_ren=1 and l2_addr=latched address until l2_ack, capture l2_rdata that cycle, then go to RESP; there is no L2 timeout.
REQ-034 RESP SHALL assert resp_valid[owner] for exactly one cycle.
REQ-035 resp_shared SHALL be 1 when any hit occurred and the request was not rdx.
REQ-036 From RESP, SHALL return to IDLE and set the pointer to (owner+1) mod CPUS.
REQ-037 Minimum latency from request to resp_valid SHALL be 4 cycles with a snoop hit and 4+L2 latency with a miss.
REQ-038 A request deasserted mid-transaction SHALL NOT abort the transaction.
REQ-039 snoop_done on the owner or on non-snooped ports SHALL be ignored.

Reset
REQ-040 RST SHALL force IDLE, pointer=0, grant=0, snoop_req=0, snoop_inv=0, l2_ren=0, resp_valid=0, timeout_err=0, and all address, data and collect registers to 0, asynchronously, including mid-transaction.

Structure
REQ-041 The state enum arb_state_t, the l2 state typedef and DATA_WIDTH SHALL live in the shared coherence package.
REQ-042 The round-robin priority picker SHALL be one sub-module, rr_picker, parametrised by CPUS, that outputs a one-hot result.

Verification
REQ-043 CPUS=4, pointer 0, ports 1 and 3 request rd together -> grant=0010; then after RESP grant=1000.
REQ-044 Port 0 rdx to 0x100, port 2 hits with data 0xA5.. -> snoop_inv=1, resp_data=0xA5.., resp_shared=0, resp_valid=0001 in cycle 4.
REQ-045 Port 1 rd, no hits, l2_ack 3 cycles after l2_ren -> l2_addr=req_addr, resp_data=l2_rdata, resp_shared=0.
REQ-046 Port 3 never asserts done -> timeout_err after 16 collect cycles, then the READ_L2 path.
REQ-047 RST asserted while in READ_L2 -> all outputs 0 immediately; the next request is arbitrated from pointer 0.
REQ-048 Ports 2 and 3 both hit -> port 2's data is returned.
